// File: rtl/apb_mem_ctrl.sv
// apb_mem_ctrl: APB4 completer driving a registered byte-laned memory.
// Adds programmable wait states, address-range checking and PSLVERR.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   psel..pstrb         APB requester inputs
//   pready/prdata/      APB response (registered, one-cycle pready)
//   pslverr
//   mem_wr/mem_rd/      single-cycle memory request (registered)
//   mem_be/mem_address/
//   mem_data_in
//   mem_data_out        registered read data from memory
module apb_mem_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_WIDTH      = 8,
  parameter int MEM_SIZE       = 256,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int WAIT_STATES    = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            psel,
  input  logic                            penable,
  input  logic                            pwrite,
  input  logic [ADDR_WIDTH-1:0]           paddr,
  input  logic [DATA_WIDTH-1:0]           pwdata,
  input  logic [DATA_WIDTH/MEM_WIDTH-1:0] pstrb,
  output logic                            pready,
  output logic [DATA_WIDTH-1:0]           prdata,
  output logic                            pslverr,
  output logic                            mem_wr,
  output logic                            mem_rd,
  output logic [DATA_WIDTH/MEM_WIDTH-1:0] mem_be,
  output logic [MEM_ADDR_WIDTH-1:0]       mem_address,
  output logic [DATA_WIDTH-1:0]           mem_data_in,
  input  logic [DATA_WIDTH-1:0]           mem_data_out
);

  localparam int LANES    = DATA_WIDTH / MEM_WIDTH;
  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int BYTE_OFF = $clog2(BYTES);
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam int WS_M1    = HAS_WAIT ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] WS_LOAD = 4'(WS_M1);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(MEM_SIZE * BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ,
    RESP
  } state_t;

  state_t state;

  logic                      is_wr;
  logic                      err;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [LANES-1:0]          strb_q;
  logic [3:0]                cnt;

  logic                      setup;
  logic                      bad;
  logic                      issue;
  logic                      req_wr;
  logic [MEM_ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]     req_data;
  logic [LANES-1:0]          req_strb;

  assign setup = psel & ~penable;

  assign bad = (|paddr[BYTE_OFF-1:0]) ||
               ({1'b0, paddr} >= LIMIT);

  // With no wait states the request is issued straight from the setup
  // edge, so it must use the live APB inputs instead of the latches.
  always_comb begin
    req_wr   = is_wr;
    req_addr = addr_q;
    req_data = wdata_q;
    req_strb = strb_q;
    if (state == IDLE) begin
      req_wr   = pwrite;
      req_addr = paddr[BYTE_OFF +: MEM_ADDR_WIDTH];
      req_data = pwdata;
      req_strb = pstrb;
    end
  end

  always_comb begin
    issue = 1'b0;
    unique case (state)
      IDLE: issue = setup && !bad && !HAS_WAIT;
      WAIT: issue = psel && (cnt == 4'd0);
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pready      <= 1'b0;
      pslverr     <= 1'b0;
      prdata      <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_be      <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
      is_wr       <= 1'b0;
      err         <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      cnt         <= '0;
    end else begin
      mem_wr  <= 1'b0;
      mem_rd  <= 1'b0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;

      unique case (state)
        IDLE: begin
          if (setup) begin
            is_wr   <= pwrite;
            addr_q  <= paddr[BYTE_OFF +: MEM_ADDR_WIDTH];
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            err     <= bad;
            if (bad) begin
              state <= RESP;
            end else if (HAS_WAIT) begin
              cnt   <= WS_LOAD;
              state <= WAIT;
            end else begin
              state <= REQ;
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= REQ;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        REQ: begin
          // An abandoned write has already been issued and stays done.
          state <= psel ? RESP : IDLE;
        end
        RESP: begin
          state <= IDLE;
          // Memory data is valid in this cycle; capture it with pready.
          if (psel) begin
            pready  <= 1'b1;
            pslverr <= err;
            if (!is_wr && !err) begin
              prdata <= mem_data_out;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        mem_wr      <= req_wr;
        mem_rd      <= ~req_wr;
        mem_be      <= req_wr ? req_strb : '1;
        mem_address <= req_addr;
        if (req_wr) begin
          mem_data_in <= req_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// tb_apb_mem_ctrl: directed bench for apb_mem_ctrl, two instances
// (no wait states and three wait states) each with a lane memory model.
module tb_apb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;

  logic        pready0, pslverr0, mem_wr0, mem_rd0;
  logic [31:0] prdata0, mem_din0, mem_dout0;
  logic [3:0]  mem_be0;
  logic [7:0]  mem_addr0;

  logic        pready3, pslverr3, mem_wr3, mem_rd3;
  logic [31:0] prdata3, mem_din3, mem_dout3;
  logic [3:0]  mem_be3;
  logic [7:0]  mem_addr3;

  logic        sel3;
  logic        o_pready, o_pslverr, o_mem_wr, o_mem_rd;
  logic [31:0] o_prdata, o_mem_din;
  logic [3:0]  o_mem_be;
  logic [7:0]  o_mem_addr;

  logic [31:0] mem0 [256];
  logic [31:0] mem3 [256];

  int n_checks = 0;
  int n_fail   = 0;

  initial forever #5 clk = ~clk;

  apb_mem_ctrl #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
    .mem_wr(mem_wr0), .mem_rd(mem_rd0), .mem_be(mem_be0),
    .mem_address(mem_addr0), .mem_data_in(mem_din0),
    .mem_data_out(mem_dout0)
  );

  apb_mem_ctrl #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready3), .prdata(prdata3), .pslverr(pslverr3),
    .mem_wr(mem_wr3), .mem_rd(mem_rd3), .mem_be(mem_be3),
    .mem_address(mem_addr3), .mem_data_in(mem_din3),
    .mem_data_out(mem_dout3)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_wr0 && mem_be0[i])
        mem0[mem_addr0][i*8 +: 8] <= mem_din0[i*8 +: 8];
      if (mem_rd0)
        mem_dout0[i*8 +: 8] <= mem_be0[i] ?
          mem0[mem_addr0][i*8 +: 8] : 8'h00;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_wr3 && mem_be3[i])
        mem3[mem_addr3][i*8 +: 8] <= mem_din3[i*8 +: 8];
      if (mem_rd3)
        mem_dout3[i*8 +: 8] <= mem_be3[i] ?
          mem3[mem_addr3][i*8 +: 8] : 8'h00;
    end
  end

  assign o_pready   = sel3 ? pready3   : pready0;
  assign o_pslverr  = sel3 ? pslverr3  : pslverr0;
  assign o_mem_wr   = sel3 ? mem_wr3   : mem_wr0;
  assign o_mem_rd   = sel3 ? mem_rd3   : mem_rd0;
  assign o_prdata   = sel3 ? prdata3   : prdata0;
  assign o_mem_din  = sel3 ? mem_din3  : mem_din0;
  assign o_mem_be   = sel3 ? mem_be3   : mem_be0;
  assign o_mem_addr = sel3 ? mem_addr3 : mem_addr0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic err,
                      output int lat, output int nwr, output int nrd,
                      output logic [7:0] maddr, output logic [3:0] mbe);
    psel0   = !sel3;
    psel3   = sel3;
    penable = 1'b0;
    pwrite  = w;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    lat = 0; nwr = 0; nrd = 0; maddr = '0; mbe = '0;
    tick;
    lat = 1;
    penable = 1'b1;
    pwdata  = 32'hBAD0BAD0;
    paddr   = a ^ 32'h4;
    while (!o_pready && lat < 40) begin
      if (o_mem_wr) nwr++;
      if (o_mem_rd) nrd++;
      if (o_mem_wr || o_mem_rd) begin
        maddr = o_mem_addr;
        mbe   = o_mem_be;
      end
      tick;
      lat++;
    end
    chk("pready_seen", o_pready, 1);
    rd  = o_prdata;
    err = o_pslverr;
    tick;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat, nwr, nrd, np;
  logic [7:0]  maddr;
  logic [3:0]  mbe;

  initial begin
    sel3 = 1'b0;
    rst_n = 1'b0;
    psel0 = 0; psel3 = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; pstrb = '0;
    tick;
    tick;
    chk("rst_pready0", pready0, 0);
    chk("rst_prdata0", prdata0, 0);
    chk("rst_memwr0", mem_wr0, 0);
    chk("rst_pready3", pready3, 0);
    chk("rst_membe3", mem_be3, 0);
    rst_n = 1'b1;
    tick;

    // full write then read, no wait states
    xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("w1_lat", lat, 3);
    chk("w1_nwr", nwr, 1);
    chk("w1_nrd", nrd, 0);
    chk("w1_addr", maddr, 8'd4);
    chk("w1_be", mbe, 4'hF);
    chk("w1_err", err, 0);
    chk("w1_pready_drop", pready0, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("r1_lat", lat, 3);
    chk("r1_data", rd, 32'hDEADBEEF);
    chk("r1_nrd", nrd, 1);
    chk("r1_be", mbe, 4'hF);
    chk("r1_err", err, 0);
    chk("r1_prdata_drop", prdata0, 0);

    // partial write
    xfer(1, 32'h10, 32'h11223344, 4'b0101, rd, err, lat, nwr, nrd,
         maddr, mbe);
    chk("w2_be", mbe, 4'b0101);
    chk("w2_prdata", rd, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("r2_data", rd, 32'hDE22BE44);

    // three wait states
    sel3 = 1'b1;
    xfer(1, 32'h0, 32'hCAFEF00D, 4'hF, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("w3_lat", lat, 6);
    chk("w3_nwr", nwr, 1);
    xfer(0, 32'h0, 32'h0, 4'h0, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("r3_lat", lat, 6);
    chk("r3_nrd", nrd, 1);
    chk("r3_data", rd, 32'hCAFEF00D);
    sel3 = 1'b0;

    // error responses
    xfer(0, 32'h400, 32'h0, 4'h0, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("e1_err", err, 1);
    chk("e1_data", rd, 0);
    chk("e1_strobes", nwr + nrd, 0);
    chk("e1_lat", lat, 2);
    xfer(1, 32'h13, 32'h55555555, 4'hF, rd, err, lat, nwr, nrd,
         maddr, mbe);
    chk("e2_err", err, 1);
    chk("e2_strobes", nwr + nrd, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("e2_intact", rd, 32'hDE22BE44);
    chk("e2_ok_after", err, 0);

    // back-to-back writes
    xfer(1, 32'h0, 32'hA0A0A0A0, 4'hF, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("b1_lat", lat, 3);
    xfer(1, 32'h4, 32'hB1B1B1B1, 4'hF, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("b2_lat", lat, 3);
    chk("b2_addr", maddr, 8'd1);
    xfer(1, 32'h8, 32'hC2C2C2C2, 4'hF, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("b3_lat", lat, 3);
    xfer(0, 32'h0, 32'h0, 4'h0, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("b1_rd", rd, 32'hA0A0A0A0);
    xfer(0, 32'h4, 32'h0, 4'h0, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("b2_rd", rd, 32'hB1B1B1B1);
    xfer(0, 32'h8, 32'h0, 4'h0, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("b3_rd", rd, 32'hC2C2C2C2);

    // reset during WAIT of a read
    sel3 = 1'b1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    tick;
    penable = 1'b1;
    tick;
    rst_n = 1'b0;
    tick;
    chk("rw_pready", pready3, 0);
    chk("rw_memrd", mem_rd3, 0);
    chk("rw_membe", mem_be3, 0);
    chk("rw_memdin", mem_din3, 0);
    chk("rw_prdata", prdata3, 0);
    rst_n = 1'b1;
    psel3 = 1'b0; penable = 1'b0;
    np = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (pready3) np++;
    end
    chk("rw_no_pready", np, 0);
    xfer(0, 32'h0, 32'h0, 4'h0, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("rw_next_lat", lat, 6);
    chk("rw_next_data", rd, 32'hCAFEF00D);
    sel3 = 1'b0;

    // psel dropped after the write was issued
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h20; pwdata = 32'h5A5A1234; pstrb = 4'hF;
    tick;
    chk("pd_memwr", mem_wr0, 1);
    chk("pd_addr", mem_addr0, 8'd8);
    psel0 = 1'b0;
    tick;
    chk("pd_memwr_off", mem_wr0, 0);
    np = 0;
    for (int i = 0; i < 4; i++) begin
      if (pready0) np++;
      tick;
    end
    chk("pd_no_pready", np, 0);
    xfer(0, 32'h20, 32'h0, 4'h0, rd, err, lat, nwr, nrd, maddr, mbe);
    chk("pd_next_lat", lat, 3);
    chk("pd_committed", rd, 32'h5A5A1234);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
